uart_rx_pkt_ctrl: RTL

//   Packet controller behind uart_rx. Consumes the received byte stream (dout_o/rx_done_o).

---
 rtl/uart_rx_pkt_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - byte-stream packet framer (SYNC ADDR LEN payload CHK) with buffered valid/ready delivery
// Optional inter-byte timeout enabled by UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
    parameter int          clkfreq       = 100_000_000,
    parameter int          baudrate      = 115_200,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          MAX_LEN       = 16,
    parameter int          TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_done_i,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_last_o,
    output logic [7:0]  pkt_addr_o,
    output logic [7:0]  pkt_len_o,
    output logic        err_chk_o,
    output logic        err_len_o,
    output logic        err_ovr_o,
    output logic        err_tmo_o,
    output logic [15:0] pkt_cnt_o
);

    localparam int         IW        = $clog2(MAX_LEN + 1);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN8  = 8'(MAX_LEN);
    localparam int         TMO_LIMIT = TIMEOUT_BYTES * 10 * (clkfreq / baudrate);
    localparam int         TW        = $clog2(TMO_LIMIT + 1);

    typedef enum logic [2:0] {
        S_SYNC, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_DELIVER
    } state_t;

    state_t          state;
    logic [7:0]      addr_q;
    logic [7:0]      len_q;
    logic [7:0]      chk_q;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   rd_nxt;
    logic [7:0]      buf_mem [2**AW];

    assign rd_nxt = rd_idx + IW'(1);

    // Payload storage carries no reset; only bytes written for the current packet are ever read.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_done_i) begin
            buf_mem[wr_idx[AW-1:0]] <= rx_data_i;
        end
    end

`ifdef UART_RX_PKT_TIMEOUT_EN
    logic [TW-1:0] timer;
    logic          err_tmo_q;
    assign err_tmo_o = err_tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_LIMIT;
    assign err_tmo_o  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state       <= S_SYNC;
            addr_q      <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            pkt_addr_o  <= '0;
            pkt_len_o   <= '0;
            err_chk_o   <= 1'b0;
            err_len_o   <= 1'b0;
            err_ovr_o   <= 1'b0;
            pkt_cnt_o   <= '0;
`ifdef UART_RX_PKT_TIMEOUT_EN
            timer       <= '0;
            err_tmo_q   <= 1'b0;
`endif
        end else begin
            err_chk_o <= 1'b0;
            err_len_o <= 1'b0;
            err_ovr_o <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (rx_done_i && rx_data_i == SYNC_BYTE) state <= S_ADDR;
                end
                S_ADDR: begin
                    if (rx_done_i) begin
                        addr_q <= rx_data_i;
                        chk_q  <= rx_data_i;
                        state  <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_done_i) begin
                        if (rx_data_i != 8'd0 && rx_data_i <= MAX_LEN8) begin
                            len_q  <= rx_data_i;
                            chk_q  <= chk_q ^ rx_data_i;
                            wr_idx <= '0;
                            state  <= S_PAYLOAD;
                        end else begin
                            err_len_o <= 1'b1;
                            state     <= S_SYNC;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_done_i) begin
                        chk_q  <= chk_q ^ rx_data_i;
                        wr_idx <= wr_idx + IW'(1);
                        if (8'(wr_idx) == len_q - 8'd1) state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_done_i) begin
                        if (rx_data_i == chk_q) begin
                            rd_idx      <= '0;
                            out_valid_o <= 1'b1;
                            out_data_o  <= buf_mem[0];
                            out_last_o  <= (len_q == 8'd1);
                            pkt_addr_o  <= addr_q;
                            pkt_len_o   <= len_q;
                            state       <= S_DELIVER;
                        end else begin
                            err_chk_o <= 1'b1;
                            state     <= S_SYNC;
                        end
                    end
                end
                S_DELIVER: begin
                    if (rx_done_i) err_ovr_o <= 1'b1;
                    if (out_ready_i) begin
                        if (out_last_o) begin
                            out_valid_o <= 1'b0;
                            out_data_o  <= '0;
                            out_last_o  <= 1'b0;
                            pkt_cnt_o   <= pkt_cnt_o + 16'd1;
                            state       <= S_SYNC;
                        end else begin
                            rd_idx     <= rd_nxt;
                            out_data_o <= buf_mem[rd_nxt[AW-1:0]];
                            out_last_o <= (8'(rd_nxt) == len_q - 8'd1);
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase
`ifdef UART_RX_PKT_TIMEOUT_EN
            // A byte on the limit cycle clears the timer instead of timing out.
            err_tmo_q <= 1'b0;
            if (state == S_ADDR || state == S_LEN || state == S_PAYLOAD || state == S_CHK) begin
                if (rx_done_i) begin
                    timer <= '0;
                end else if (timer == TW'(TMO_LIMIT - 1)) begin
                    timer     <= '0;
                    err_tmo_q <= 1'b1;
                    state     <= S_SYNC;
                end else begin
                    timer <= timer + TW'(1);
                end
            end else begin
                timer <= '0;
            end
`endif
        end
    end

endmodule
